ms_io_bridge: RTL
=================

// Module: ms_io_bridge
// PURPOSE
//  Sits downstream of the processor top's single IO port (AIoAddr/AIoMosi/AIoWrSize/AIoRdSize/AIoBusy) and fans it out to CSlotCnt peripheral slots.
//  Decodes slot from address, runs one strobe/ack transaction per access, sizes read data, holds AIoBusy until done.
//  Guarantees completion via per-access timeout; unmapped/timed-out accesses are logged in sticky error regs.
// PARAMETERS
//  CSlotCnt   4   number of peripheral slots; slot index = AIoAddr[15:8], 1..256
//  CTimeout   15  max wait cycles (enabled clocks) for slot ack after strobe, 1..255
// PORTS
//  AClkH        in   1            system clock; one clock domain only
//  AResetH      in   1            reset, synchronous, active-high
//  AClkHEn      in   1            clock enable; all state/counters advance only when 1
//  AIoAddr      in   16           IO address from processor
//  AIoMosi      in   64           write data
//  AIoWrSize    in   4            write byte count (0=none,1,2,4,8)
//  AIoRdSize    in   4            read byte count (0=none,1,2,4,8)
//  AIoMiso      out  64           read data, valid in cycle AIoBusy falls
//  AIoBusy      out  1            stall to processor
//  ASlotAddr    out  8            AIoAddr[7:0] registered at accept
//  ASlotMosi    out  64           write data registered at accept
//  ASlotWrSize  out  CSlotCnt*4   per-slot write strobe, 1-cycle pulse
//  ASlotRdSize  out  CSlotCnt*4   per-slot read strobe, 1-cycle pulse
//  ASlotMiso    in   CSlotCnt*64  per-slot read data, sampled with ack
//  ASlotAck     in   CSlotCnt     per-slot completion pulse
//  AErrClr      in   1            clears sticky error regs
//  AErr         out  2            sticky: [0]=unmapped slot, [1]=timeout
//  AErrAddr     out  16           address of first error since clear
// BEHAVIOUR
//  Request present: Req = |AIoWrSize | |AIoRdSize. AIoBusy = Req & (State!=DONE) (combinational).
//  FSM: IDLE -Req-> STRB (latch addr/data/sizes/slot; Wr nonzero => Rd ignored) -> WAIT -ack|timeout-> DONE -> IDLE.
//   STRB: drive selected slot's Wr/RdSize for exactly one enabled cycle; all other slots 0.
//   Unmapped slot (idx>=CSlotCnt): no strobe, STRB->DONE, Miso=0, set AErr[0].
//   WAIT: counter from 0; ack of selected slot -> DONE, capture ASlotMiso. Ack from other slots ignored.
//    Counter==CTimeout without ack -> DONE, Miso=64'hFFFF_FFFF_FFFF_FFFF, set AErr[1].
//   Ack in same cycle as counter reaches CTimeout: ack wins, no error.
//   DONE: AIoMiso held, AIoBusy=0 for one cycle; writes return Miso=0.
//  Read sizing: size 1/2/4 zero-extends [7:0]/[15:0]/[31:0]; 8 passes 64 bits; other nonzero = 8.
//  Latency: mapped slot with ack in first WAIT cycle -> AIoBusy low 3 enabled cycles after Req.
//  Back-to-back: Req still high in DONE cycle is treated as new access only from IDLE next cycle.
//  AErrAddr loads only when AErr==0 and an error is set; AErrClr same cycle as new error: error wins.
//  AClkHEn=0: state, counter, strobes frozen; strobes held (slots also gated by AClkHEn).
//  Reset (any state, incl. mid-WAIT): State=IDLE, counter=0, all strobes 0, AIoMiso=0, AErr=0, AErrAddr=0, ASlotAddr=0, ASlotMosi=0; late ack after reset ignored.
// STRUCTURE
//  Shared include ms_io_defs: FSM state encodings (IDLE/STRB/WAIT/DONE), size codes, timeout fill constant.
//  One sub-module ms_io_rdsize: combinational size mask (size[3:0], data[63:0] -> data[63:0]); rest flat in bridge.
//  Slot Miso mux reuses one-hot select built at accept.
// TESTING
//  1 Rd size 4, addr 16'h0210, slot2 acks 1st WAIT cycle with 64'h1122_3344_5566_7788 -> Miso=64'h5566_7788, busy 3 cycles.
//  2 Wr size 8, addr 16'h0104, data 64'hA5 -> slot1 WrSize=8 one cycle, ASlotAddr=8'h04, others 0, Miso=0.
//  3 Rd addr 16'h0700 (CSlotCnt=4) -> no strobe, Miso=0, AErr=2'b01, AErrAddr=16'h0700; AErrClr -> AErr=0.
//  4 Rd slot3 never acks -> busy CTimeout+2 cycles, Miso=all-ones, AErr[1]=1; ack at exactly CTimeout -> no error.
//  5 AClkHEn toggling 1/0 during slot wait -> counter only counts enabled cycles; same Miso as enabled-only run.
//  6 AResetH asserted in WAIT, then slot acks -> IDLE, strobes 0, Miso 0; next Rd completes normally.

Source files
------------

// File: rtl/ms_io_bridge_pkg.sv
// Shared definitions for the IO bridge: FSM states, transfer size codes,
// bus widths and the fill pattern returned on a slot timeout.
package ms_io_bridge_pkg;

  localparam int IO_ADDR_W   = 16;
  localparam int IO_DATA_W   = 64;
  localparam int IO_SIZE_W   = 4;
  localparam int SLOT_ADDR_W = 8;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ioState_t;

  localparam logic [IO_SIZE_W-1:0] SIZE_NONE = 4'd0;
  localparam logic [IO_SIZE_W-1:0] SIZE_B1   = 4'd1;
  localparam logic [IO_SIZE_W-1:0] SIZE_B2   = 4'd2;
  localparam logic [IO_SIZE_W-1:0] SIZE_B4   = 4'd4;
  localparam logic [IO_SIZE_W-1:0] SIZE_B8   = 4'd8;

  localparam logic [IO_DATA_W-1:0] TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

  // A write takes priority; a read size presented alongside it is dropped.
  function automatic logic [IO_SIZE_W-1:0] effRdSize(input logic [IO_SIZE_W-1:0] wrSize,
                                                     input logic [IO_SIZE_W-1:0] rdSize);
    return (wrSize != SIZE_NONE) ? SIZE_NONE : rdSize;
  endfunction

endpackage

// File: rtl/ms_io_bridge_if.sv
// Processor-side IO port of the bridge: address, write data, sizes, read data, stall.
interface ms_io_bridge_if;
  import ms_io_bridge_pkg::*;

  logic [IO_ADDR_W-1:0] AIoAddr;
  logic [IO_DATA_W-1:0] AIoMosi;
  logic [IO_SIZE_W-1:0] AIoWrSize;
  logic [IO_SIZE_W-1:0] AIoRdSize;
  logic [IO_DATA_W-1:0] AIoMiso;
  logic                 AIoBusy;

  modport master (
    output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
    input  AIoMiso, AIoBusy
  );

  modport slave (
    input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
    output AIoMiso, AIoBusy
  );

endinterface

// File: rtl/ms_io_bridge_rdsize.sv
// Read-data sizing: zero-extends 1/2/4-byte reads, passes 8 bytes, and treats any
// other nonzero code as a full 64-bit read. Size 0 (no read) yields zero.
module ms_io_rdsize
  import ms_io_bridge_pkg::*;
(
  input  logic [IO_SIZE_W-1:0] size,
  input  logic [IO_DATA_W-1:0] data,
  output logic [IO_DATA_W-1:0] dataOut
);

  always_comb begin
    dataOut = '0;
    case (size)
      SIZE_NONE: dataOut = '0;
      SIZE_B1:   dataOut = {56'd0, data[7:0]};
      SIZE_B2:   dataOut = {48'd0, data[15:0]};
      SIZE_B4:   dataOut = {32'd0, data[31:0]};
      default:   dataOut = data;
    endcase
  end

endmodule

// File: rtl/ms_io_bridge.sv
// Fans the processor's single IO port out to CSlotCnt peripheral slots: one
// strobe/ack transaction per access, bounded by a timeout, with sticky error logging.
module ms_io_bridge
  import ms_io_bridge_pkg::*;
#(
  parameter int CSlotCnt = 4,
  parameter int CTimeout = 15
) (
  input  logic                          AClkH,
  input  logic                          AResetH,
  input  logic                          AClkHEn,
  ms_io_bridge_if.slave                 io,
  output logic [SLOT_ADDR_W-1:0]        ASlotAddr,
  output logic [IO_DATA_W-1:0]          ASlotMosi,
  output logic [CSlotCnt*IO_SIZE_W-1:0] ASlotWrSize,
  output logic [CSlotCnt*IO_SIZE_W-1:0] ASlotRdSize,
  input  logic [CSlotCnt*IO_DATA_W-1:0] ASlotMiso,
  input  logic [CSlotCnt-1:0]           ASlotAck,
  input  logic                          AErrClr,
  output logic [1:0]                    AErr,
  output logic [IO_ADDR_W-1:0]          AErrAddr
);

  ioState_t                      state;
  logic [CNT_W-1:0]              waitCnt;
  logic [CNT_W-1:0]              waitCntNext;
  logic [CSlotCnt-1:0]           slotSel;
  logic [CSlotCnt-1:0]           acceptSel;
  logic [CSlotCnt*IO_SIZE_W-1:0] acceptWr;
  logic [CSlotCnt*IO_SIZE_W-1:0] acceptRd;
  logic [IO_SIZE_W-1:0]          acceptRdSize;
  logic [IO_SIZE_W-1:0]          rdSizeQ;
  logic [IO_ADDR_W-1:0]          addrQ;
  logic [IO_DATA_W-1:0]          selMiso;
  logic [IO_DATA_W-1:0]          sizedMiso;
  logic                          req;
  logic                          selAck;
  logic                          timeoutHit;
  logic [1:0]                    errSet;
  logic [1:0]                    errBase;

  assign req        = (|io.AIoWrSize) | (|io.AIoRdSize);
  assign io.AIoBusy = req & (state != DONE);

  assign acceptRdSize = effRdSize(io.AIoWrSize, io.AIoRdSize);

  // Slot indices at or beyond CSlotCnt match no bit, so an all-zero select marks unmapped.
  always_comb begin
    acceptSel = '0;
    acceptWr  = '0;
    acceptRd  = '0;
    for (int i = 0; i < CSlotCnt; i++) begin
      acceptSel[i] = (io.AIoAddr[15:8] == 8'(i));
      acceptWr[i*IO_SIZE_W +: IO_SIZE_W] = acceptSel[i] ? io.AIoWrSize : SIZE_NONE;
      acceptRd[i*IO_SIZE_W +: IO_SIZE_W] = acceptSel[i] ? acceptRdSize : SIZE_NONE;
    end
  end

  always_comb begin
    selMiso = '0;
    for (int i = 0; i < CSlotCnt; i++) begin
      if (slotSel[i]) selMiso = selMiso | ASlotMiso[i*IO_DATA_W +: IO_DATA_W];
    end
  end

  assign selAck      = |(ASlotAck & slotSel);
  assign waitCntNext = waitCnt + CNT_W'(1);
  assign timeoutHit  = (waitCntNext == CNT_W'(CTimeout));

  ms_io_rdsize uRdSize (
    .size    (rdSizeQ),
    .data    (selMiso),
    .dataOut (sizedMiso)
  );

  // An ack arriving in the final wait cycle takes precedence over the timeout.
  always_comb begin
    errSet = 2'b00;
    if (state == STRB && slotSel == '0) errSet[0] = 1'b1;
    if (state == WAIT && !selAck && timeoutHit) errSet[1] = 1'b1;
  end

  assign errBase = AErrClr ? 2'b00 : AErr;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state       <= IDLE;
      waitCnt     <= '0;
      slotSel     <= '0;
      rdSizeQ     <= SIZE_NONE;
      addrQ       <= '0;
      ASlotAddr   <= '0;
      ASlotMosi   <= '0;
      ASlotWrSize <= '0;
      ASlotRdSize <= '0;
      io.AIoMiso  <= '0;
    end else if (AClkHEn) begin
      case (state)
        IDLE: begin
          if (req) begin
            addrQ       <= io.AIoAddr;
            ASlotAddr   <= io.AIoAddr[7:0];
            ASlotMosi   <= io.AIoMosi;
            rdSizeQ     <= acceptRdSize;
            slotSel     <= acceptSel;
            ASlotWrSize <= acceptWr;
            ASlotRdSize <= acceptRd;
            state       <= STRB;
          end
        end
        STRB: begin
          ASlotWrSize <= '0;
          ASlotRdSize <= '0;
          if (slotSel != '0) begin
            waitCnt <= '0;
            state   <= WAIT;
          end else begin
            io.AIoMiso <= '0;
            state      <= DONE;
          end
        end
        WAIT: begin
          if (selAck) begin
            io.AIoMiso <= sizedMiso;
            state      <= DONE;
          end else if (timeoutHit) begin
            io.AIoMiso <= TIMEOUT_FILL;
            state      <= DONE;
          end else begin
            waitCnt <= waitCntNext;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A clear and a new error in the same cycle leave the new error set and logged.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      AErr     <= 2'b00;
      AErrAddr <= '0;
    end else if (AClkHEn) begin
      AErr <= errBase | errSet;
      if (errSet != 2'b00 && errBase == 2'b00) AErrAddr <= addrQ;
      else if (AErrClr)                        AErrAddr <= '0;
    end
  end

endmodule
